// File: rtl/matmul_mem_seq_pkg.sv
// matmul_mem_seq_pkg: shared state codes, byte-lane constants and default timeout
package matmul_mem_seq_pkg;
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_READ      = 3'd1;
    localparam logic [2:0] S_LAUNCH    = 3'd2;
    localparam logic [2:0] S_WAIT_CLR  = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;
    localparam logic [2:0] S_WRITE     = 3'd5;
    localparam logic [2:0] S_FIN       = 3'd6;
    localparam int BYTE_W = 8;
    localparam int LANES = 4;
    localparam logic [3:0] RD_BYTES = 4'd8;
    localparam logic [3:0] LAST_LANE = 4'd3;
    localparam int DEF_TIMEOUT = 64;
    typedef logic [1:0] lane_t;
endpackage

// File: rtl/matmul_mem_seq_if.sv
// matmul_mem_seq_if: data-memory port and matrix-unit port owned by the sequencer
interface matmul_mem_seq_if
    import matmul_mem_seq_pkg::*;
#(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] mem_addr;
    logic mem_rd_en;
    logic [BYTE_W-1:0] mem_rdata;
    logic mem_wr_en;
    logic [BYTE_W-1:0] mem_wdata;
    logic mm_start;
    logic [LANES*BYTE_W-1:0] mm_a;
    logic [LANES*BYTE_W-1:0] mm_b;
    logic [LANES*BYTE_W-1:0] mm_c;
    logic mm_done;
    modport master (
        output mem_addr, mem_rd_en, mem_wr_en, mem_wdata, mm_start, mm_a, mm_b,
        input mem_rdata, mm_c, mm_done
    );
    modport slave (
        input mem_addr, mem_rd_en, mem_wr_en, mem_wdata, mm_start, mm_a, mm_b,
        output mem_rdata, mm_c, mm_done
    );
endinterface

// File: rtl/matmul_byte_packer.sv
// matmul_byte_packer: 32-bit register written per byte lane or as a whole word, read back per lane
module matmul_byte_packer
    import matmul_mem_seq_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic byte_en,
    input  lane_t lane,
    input  logic [BYTE_W-1:0] byte_in,
    input  logic word_en,
    input  logic [LANES*BYTE_W-1:0] word_in,
    input  lane_t rd_lane,
    output logic [LANES*BYTE_W-1:0] word,
    output logic [BYTE_W-1:0] byte_out
);
    // a whole-word load takes priority over a single-lane update
    always_ff @(posedge clk or posedge reset)
        if (reset) word <= '0;
        else if (word_en) word <= word_in;
        else if (byte_en) word[{lane, 3'b000} +: BYTE_W] <= byte_in;
    assign byte_out = word[{rd_lane, 3'b000} +: BYTE_W];
endmodule

// File: rtl/matmul_mem_seq.sv
// matmul_mem_seq: loads A/B from memory, runs the 2x2 matrix unit, writes C back
module matmul_mem_seq
    import matmul_mem_seq_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int TIMEOUT = DEF_TIMEOUT
)(
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic [ADDR_W-1:0] src_a_addr,
    input  logic [ADDR_W-1:0] src_b_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    output logic busy,
    output logic done,
    output logic error,
    matmul_mem_seq_if.master bus
);
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [2:0] state;
    logic [3:0] idx;
    logic [CW-1:0] wait_cnt;
    logic [ADDR_W-1:0] a_base, b_base, d_base;
    logic [2:0] cap_k;
    logic rd_issue, rd_cap, wr_st, wait_st, timeout_hit, wait_go;
    logic [BYTE_W-1:0] c_byte, unused_a_byte, unused_b_byte;
    logic [LANES*BYTE_W-1:0] unused_c_word;

    assign cap_k = idx[2:0] - 3'd1;
    assign rd_issue = state == S_READ && idx < RD_BYTES;
    assign rd_cap = state == S_READ && idx != 4'd0;
    assign wr_st = state == S_WRITE;
    assign wait_st = state == S_WAIT_CLR || state == S_WAIT_DONE;
    assign wait_go = state == S_WAIT_CLR ? !bus.mm_done : bus.mm_done;
    assign timeout_hit = wait_st && wait_cnt == CW'(TIMEOUT - 1);

    assign busy = state != S_IDLE && state != S_FIN;
    assign done = state == S_FIN;
    assign bus.mem_rd_en = rd_issue;
    assign bus.mem_wr_en = wr_st;
    assign bus.mem_addr = rd_issue ? (idx[2] ? b_base : a_base) + ADDR_W'(idx[1:0])
                        : wr_st ? d_base + ADDR_W'(idx[1:0]) : '0;
    assign bus.mem_wdata = wr_st ? c_byte : '0;
    assign bus.mm_start = state == S_LAUNCH;

    matmul_byte_packer u_pack_a (
        .clk(clk), .reset(reset),
        .byte_en(rd_cap && !cap_k[2]), .lane(cap_k[1:0]), .byte_in(bus.mem_rdata),
        .word_en(1'b0), .word_in('0), .rd_lane(2'd0),
        .word(bus.mm_a), .byte_out(unused_a_byte)
    );
    matmul_byte_packer u_pack_b (
        .clk(clk), .reset(reset),
        .byte_en(rd_cap && cap_k[2]), .lane(cap_k[1:0]), .byte_in(bus.mem_rdata),
        .word_en(1'b0), .word_in('0), .rd_lane(2'd0),
        .word(bus.mm_b), .byte_out(unused_b_byte)
    );
    matmul_byte_packer u_pack_c (
        .clk(clk), .reset(reset),
        .byte_en(1'b0), .lane(2'd0), .byte_in('0),
        .word_en(state == S_WAIT_DONE && bus.mm_done), .word_in(bus.mm_c), .rd_lane(idx[1:0]),
        .word(unused_c_word), .byte_out(c_byte)
    );

    // sequencer: read 8 bytes plus a drain cycle, launch, two-phase wait with timeout, write 4 bytes
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= S_IDLE;
            idx <= '0;
            wait_cnt <= '0;
            a_base <= '0;
            b_base <= '0;
            d_base <= '0;
            error <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    state <= S_READ;
                    idx <= '0;
                    a_base <= src_a_addr;
                    b_base <= src_b_addr;
                    d_base <= dst_addr;
                    error <= 1'b0;
                end
                S_READ: begin
                    idx <= idx == RD_BYTES ? 4'd0 : idx + 4'd1;
                    state <= idx == RD_BYTES ? S_LAUNCH : S_READ;
                end
                S_LAUNCH: begin
                    wait_cnt <= '0;
                    state <= S_WAIT_CLR;
                end
                S_WAIT_CLR, S_WAIT_DONE: begin
                    wait_cnt <= wait_cnt + CW'(1);
                    if (wait_go) state <= state == S_WAIT_CLR ? S_WAIT_DONE : S_WRITE;
                    else if (timeout_hit) begin
                        state <= S_FIN;
                        error <= 1'b1;
                    end
                end
                S_WRITE: begin
                    idx <= idx == LAST_LANE ? 4'd0 : idx + 4'd1;
                    state <= idx == LAST_LANE ? S_FIN : S_WRITE;
                end
                default: state <= S_IDLE;
            endcase
        end
endmodule

// File: doc/matmul_mem_seq.md
Name: matmul_mem_seq

Overview:
Memory-side sequencer that feeds and drains the 2x2 8-bit matrix-multiply unit. On a start command it reads eight operand bytes (A then B, row-major) from data memory and packs them into two 32-bit operands. It then launches the multiplier, waits for completion, and writes the four result bytes back to memory. It sits between the core's execute/control stage and the matrix unit, and owns the data-memory port while busy.

Parameters:
ADDR_W, 8, data-memory address width; addresses wrap modulo 2^ADDR_W
TIMEOUT, 64, max cycles spent waiting on the multiplier before aborting

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  command pulse; sampled only in IDLE
src_a_addr  in  ADDR_W  base address of A (4 bytes)
src_b_addr  in  ADDR_W  base address of B (4 bytes)
dst_addr  in  ADDR_W  base address of C (4 bytes)
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle completion pulse
error  out  1  sticky timeout flag; cleared on next accepted start
mem_addr  out  ADDR_W  memory address
mem_rd_en  out  1  read request; mem_rdata valid the following cycle
mem_rdata  in  8  read data
mem_wr_en  out  1  write strobe
mem_wdata  out  8  write data
mm_start  out  1  drives multiplier is_matrix_mult
mm_a  out  32  packed A {a11,a10,a01,a00}
mm_b  out  32  packed B {b11,b10,b01,b00}
mm_c  in  32  packed result {c11,c10,c01,c00}
mm_done  in  1  multiplier done level (held high until next launch)

Behaviour:
- Reset (async): state IDLE; busy, done, error, mem_rd_en, mem_wr_en, mm_start = 0; mem_addr, mem_wdata, mm_a, mm_b = 0; index counters = 0.
- Reset while busy aborts the operation immediately: no further memory accesses, no done pulse.
- States: IDLE -> READ -> LAUNCH -> WAIT_CLR -> WAIT_DONE -> WRITE -> FIN -> IDLE.
- IDLE: on start=1, latch the three addresses, clear error, go to READ. start is ignored in every other state.
- READ: 8 consecutive issue cycles with mem_rd_en=1.
  - Byte k=0..3 is read from src_a_addr+k; byte k=4..7 from src_b_addr+(k-4). Address addition wraps.
  - Data returns one cycle after each issue and is captured into mm_a/mm_b bits [8j+7:8j], j = k mod 4.
  - The last capture happens one cycle after the last issue (drain cycle, mem_rd_en=0), then go to LAUNCH.
- LAUNCH: mm_start=1 for exactly one cycle. mm_a/mm_b are stable from this cycle until FIN.
- WAIT_CLR: wait for mm_done=0, which guards against a stale done level from a prior operation.
- WAIT_DONE: wait for mm_done=1; capture mm_c on that cycle.
- Timeout: one wait counter covers both wait states. If it reaches TIMEOUT, set error=1, perform no writes, go to FIN.
- WRITE: 4 cycles with mem_wr_en=1, mem_addr=dst_addr+j, mem_wdata=captured C byte j, for j=0..3.
- FIN: done=1 for one cycle while busy=0; next cycle return to IDLE. A new start can be accepted the cycle after FIN.
- Arithmetic: all addresses are ADDR_W bits and wrap modulo 2^ADDR_W. No arithmetic on data bytes.
- mem_rd_en and mem_wr_en are never high in the same cycle.
- Nominal latency, from the start sample edge to done: 1 + 9 + 1 + WAIT + 4 + 1 cycles, where WAIT is the multiplier response time.

Decomposition:
- Shared package: state encoding constants (IDLE..FIN), byte-lane index constants, default TIMEOUT.
- One natural sub-module, matmul_byte_packer: a shift/lane-select register that assembles 4 bytes into 32 bits and unpacks 32 bits to bytes by index. Instantiate it for A, B and C.
- Memory and multiplier remain external.

Test Plan:
- Basic: memory holds A=[1,2;3,4] at 0x10, B=[5,6;7,8] at 0x20, dst=0x30, with an ideal multiplier model. Required: mm_a=0x04030201, mm_b=0x08070605; memory 0x30..0x33 = 0x13,0x16,0x2B,0x32; one done pulse; error=0.
- Address wrap: src_a=0xFE, src_b=0x00, dst=0xFF. Required: reads of FE,FF,00,01; writes to FF,00,01,02.
- Timeout: multiplier model holds mm_done=0. Required: error=1 after 64 wait cycles, zero write strobes, done pulses once; error clears on the next start.
- Stale done: mm_done held 1 before launch, falling 2 cycles after mm_start. Required: the block does not proceed until mm_done goes 0 then 1; results are correct.
- Start while busy: a second start pulse during WAIT_DONE is ignored. Required: exactly one operation and one done pulse.
- Reset mid-WRITE: assert reset after the 2nd write strobe. Required: all outputs 0 immediately, no further writes, no done pulse; a fresh start afterwards completes normally.
